// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with request-to-send, odd parity, ACK check and timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [2:0] IDLE = 3'd0, RTS = 3'd1, REQ = 3'd2, START = 3'd3,
                           DATA = 3'd4, STOP = 3'd5, ACK = 3'd6, WREL = 3'd7;

    logic [1:0]            c_sync_q, c_sync_d, d_sync_q, d_sync_d;
    logic [FILTER_LEN-1:0] c_filt_q, c_filt_d, d_filt_q, d_filt_d;
    logic                  fc_q, fc_d, fd_q, fd_d, fall_c;
    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [8:0]            shreg_q, shreg_d;
    logic [3:0]            n_q, n_d;
    logic                  drv_c, drv_d, done, err;

    always_comb begin
        c_sync_d = {c_sync_q[0], ps2c};
        d_sync_d = {d_sync_q[0], ps2d};
        c_filt_d = {c_filt_q[FILTER_LEN-2:0], c_sync_q[1]};
        d_filt_d = {d_filt_q[FILTER_LEN-2:0], d_sync_q[1]};
        fc_d = (&c_filt_q) ? 1'b1 : (~|c_filt_q) ? 1'b0 : fc_q;
        fd_d = (&d_filt_q) ? 1'b1 : (~|d_filt_q) ? 1'b0 : fd_q;
        fall_c = fc_q & ~fc_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        shreg_d = shreg_q;
        n_d = n_q;
        done = 1'b0;
        err = 1'b0;
        case (state_q)
            IDLE: if (wr_ps2) begin
                state_d = RTS;
                cnt_d = '0;
                shreg_d = {~^din, din};
            end
            RTS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    state_d = REQ;
                    cnt_d = '0;
                end
            end
            REQ: begin
                state_d = START;
                cnt_d = '0;
            end
            START: if (fall_c) begin
                state_d = DATA;
                n_d = 4'd8;
            end
            DATA: if (fall_c) begin
                shreg_d = {1'b0, shreg_q[8:1]};
                n_d = n_q - 1'b1;
                if (n_q == 4'd0) state_d = STOP;
            end
            STOP: if (fall_c) state_d = ACK;
            ACK: if (fall_c && fd_q) begin
                err = 1'b1;
                state_d = IDLE;
            end else if (!fc_q && !fd_q) begin
                state_d = WREL;
            end
            WREL: if (fc_q && fd_q) begin
                done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // device-clocked states: any clock fall or state change restarts the timeout
        if (state_q >= START) begin
            cnt_d = (fall_c || state_d != state_q) ? '0 : cnt_q + 1'b1;
            if (!fall_c && state_d == state_q && cnt_q == CW'(TIMEOUT_CYCLES)) begin
                err = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_sync_q <= '1;
            d_sync_q <= '1;
            c_filt_q <= '1;
            d_filt_q <= '1;
            fc_q <= 1'b1;
            fd_q <= 1'b1;
            state_q <= IDLE;
            cnt_q <= '0;
            shreg_q <= '0;
            n_q <= '0;
        end else begin
            c_sync_q <= c_sync_d;
            d_sync_q <= d_sync_d;
            c_filt_q <= c_filt_d;
            d_filt_q <= d_filt_d;
            fc_q <= fc_d;
            fd_q <= fd_d;
            state_q <= state_d;
            cnt_q <= cnt_d;
            shreg_q <= shreg_d;
            n_q <= n_d;
        end
    end

    always_comb begin
        drv_c = (state_q == RTS) || (state_q == REQ);
        drv_d = (state_q == REQ) || (state_q == START) || (state_q == DATA && !shreg_q[0]);
        tx_idle = (state_q == IDLE);
        tx_done_tick = done & ~reset;
        tx_err_tick = err & ~reset;
    end

    assign ps2c = drv_c ? 1'b0 : 1'bz;
    assign ps2d = drv_d ? 1'b0 : 1'bz;
endmodule
